// File: rtl/emboss_pkg.sv
`default_nettype none
// ============================================================================
// Module      : emboss_pkg
// Description : Definitions shared by the emboss window generator and the
//               emboss core: default pixel width, window index map for
//               packing/unpacking a 3x3 window bus, and kernel coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
package emboss_pkg;

  // Default pixel width.
  localparam int DEF_PIX_W = 8;

  // Window index map. Index = row*3 + col, so P00 occupies the LSBs of a
  // packed window and P22 the MSBs.
  localparam int P00   = 0;
  localparam int P01   = 1;
  localparam int P02   = 2;
  localparam int P10   = 3;
  localparam int P11   = 4;
  localparam int P12   = 5;
  localparam int P20   = 6;
  localparam int P21   = 7;
  localparam int P22   = 8;
  localparam int WIN_N = 9;

  // Emboss kernel (row-major) and output bias.
  localparam int signed K00 = -2;
  localparam int signed K01 = -1;
  localparam int signed K02 = 0;
  localparam int signed K10 = -1;
  localparam int signed K11 = 1;
  localparam int signed K12 = 1;
  localparam int signed K20 = 0;
  localparam int signed K21 = 1;
  localparam int signed K22 = 2;
  localparam int        BIAS = 128;

  // Window index of row r, column c.
  function automatic int win_idx(input int r, input int c);
    return r * 3 + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/emboss_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : emboss_line_buf
// Description : Single-clock DEPTH x WIDTH line memory. Asynchronous read of
//               the addressed entry; synchronous write at the same address,
//               so a same-cycle read returns the old contents.
// Ports       : clk     - clock, rising edge
//               i_we    - write enable
//               i_addr  - read/write address (column)
//               i_wdata - write data
//               o_rdata - read data (contents before this cycle's write)
// Revision    : 1.0 - initial release
// ============================================================================
module emboss_line_buf #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  // Not reset: contents are never exposed before being rewritten.
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/emboss_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : emboss_window_gen
// Description : Streaming 3x3 window generator for the emboss core. Builds
//               neighbourhoods from a raster pixel stream using two line
//               buffers and a 3x3 shift window; emits interior windows only
//               through a valid/ready handshake.
// Ports       : clk, rst_n        - clock / async active-low reset
//               in_valid/in_ready - pixel handshake
//               in_pix, in_sof    - pixel and start-of-frame marker
//               win_valid/win_ready - window handshake
//               win_o             - packed window (p00 at LSBs .. p22 at MSBs)
//               win_last          - last window of the frame
//               win_cx, win_cy    - window centre coordinates
//                                   (only when EMBOSS_WIN_POS_EN is defined)
// Options     : EMBOSS_WIN_POS_EN - adds win_cx / win_cy outputs
// Revision    : 1.0 - initial release
// ============================================================================
module emboss_window_gen
  import emboss_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pix,
  input  logic                   in_sof,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [9*PIX_W-1:0]     win_o,
  output logic                   win_last
`ifdef EMBOSS_WIN_POS_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_cx,
  output logic [$clog2(IMG_H)-1:0] win_cy
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] c_x_last = XW'(IMG_W - 1);
  localparam logic [YW-1:0] c_y_last = YW'(IMG_H - 1);
  localparam logic [XW-1:0] c_x_two  = XW'(2);
  localparam logic [YW-1:0] c_y_two  = YW'(2);

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [PIX_W-1:0] r_win [WIN_N];
  logic             r_valid;
  logic             r_last;

  logic             w_acc;
  logic [XW-1:0]    w_x;
  logic [YW-1:0]    w_y;
  logic             w_interior;
  logic             w_frame_end;
  logic [PIX_W-1:0] w_top;
  logic [PIX_W-1:0] w_mid;

  assign in_ready = !r_valid || win_ready;
  assign w_acc    = in_valid && in_ready;

  // A start-of-frame pixel is (0,0) whatever the counters say.
  assign w_x = in_sof ? '0 : r_x;
  assign w_y = in_sof ? '0 : r_y;

  assign w_interior  = (w_x >= c_x_two) && (w_y >= c_y_two);
  assign w_frame_end = (w_x == c_x_last) && (w_y == c_y_last);

  // lb_a holds row y-1, lb_b row y-2; on each accept the column shifts down.
  emboss_line_buf #(
    .DEPTH  (IMG_W),
    .WIDTH  (PIX_W),
    .ADDR_W (XW)
  ) u_lb_a (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (w_x),
    .i_wdata (in_pix),
    .o_rdata (w_mid)
  );

  emboss_line_buf #(
    .DEPTH  (IMG_W),
    .WIDTH  (PIX_W),
    .ADDR_W (XW)
  ) u_lb_b (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (w_x),
    .i_wdata (w_mid),
    .o_rdata (w_top)
  );

  // Raster position counters with explicit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_acc) begin
      if (w_x == c_x_last) begin
        r_x <= '0;
        r_y <= (w_y == c_y_last) ? '0 : w_y + YW'(1);
      end else begin
        r_x <= w_x + XW'(1);
        r_y <= w_y;
      end
    end
  end

  // 3x3 shift window: columns move left, new column enters column 2.
  // Updates on every accept; only interior accepts publish it as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[win_idx(r, 0)] <= r_win[win_idx(r, 1)];
        r_win[win_idx(r, 1)] <= r_win[win_idx(r, 2)];
      end
      r_win[P02] <= w_top;
      r_win[P12] <= w_mid;
      r_win[P22] <= in_pix;
    end
  end

  // Output handshake. A new interior accept in the same cycle as a consume
  // keeps valid high, giving one window per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_acc && w_interior) begin
      r_valid <= 1'b1;
      r_last  <= w_frame_end;
    end else if (win_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign win_valid = r_valid;
  assign win_last  = r_last;

  for (genvar i = 0; i < WIN_N; i++) begin : g_pack
    assign win_o[i*PIX_W +: PIX_W] = r_win[i];
  end

`ifdef EMBOSS_WIN_POS_EN
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;

  // Centre is one column and one row behind the accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (w_acc && w_interior) begin
      r_cx <= w_x - XW'(1);
      r_cy <= w_y - YW'(1);
    end
  end

  assign win_cx = r_cx;
  assign win_cy = r_cy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_emboss_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_emboss_window_gen
// Description : Self-checking bench for emboss_window_gen (IMG_W=5, IMG_H=4,
//               pixel value = y*16 + x + frame base).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emboss_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_sof    = 1'b0;
  logic          win_ready = 1'b1;
  logic [PW-1:0] in_pix    = '0;
  logic          in_ready;
  logic          win_valid;
  logic          win_last;
  logic [9*PW-1:0] win_o;
`ifdef EMBOSS_WIN_POS_EN
  logic [2:0] win_cx;
  logic [1:0] win_cy;
`endif

  emboss_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .in_sof    (in_sof),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_o     (win_o),
    .win_last  (win_last)
`ifdef EMBOSS_WIN_POS_EN
    ,
    .win_cx    (win_cx),
    .win_cy    (win_cy)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected windows of one frame: top-left pixel, last flag, centre.
  typedef struct {
    logic [7:0] p00;
    logic       last;
    int         cx;
    int         cy;
  } vec_t;
  vec_t tbl [6];

  typedef struct {
    logic [9*PW-1:0] win;
    logic            last;
    int              cyc;
    int              cx;
    int              cy;
  } cap_t;
  cap_t cap [$];
  cap_t mc;

  // Record every window transfer.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && win_valid && win_ready) begin
        mc.win  = win_o;
        mc.last = win_last;
        mc.cyc  = cyc;
`ifdef EMBOSS_WIN_POS_EN
        mc.cx   = int'(win_cx);
        mc.cy   = int'(win_cy);
`else
        mc.cx   = -1;
        mc.cy   = -1;
`endif
        cap.push_back(mc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [9*PW-1:0] got, input logic [9*PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic logic [9*PW-1:0] exp_win(input logic [7:0] base, input logic [7:0] p00);
    logic [9*PW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*PW +: PW] = base + p00 + 8'(r*16 + c);
    return w;
  endfunction

  // Called at negedge+1; returns at negedge+1 after the pixel is accepted.
  task automatic push(input logic [7:0] p, input logic sof);
    int n;
    in_valid = 1'b1;
    in_pix   = p;
    in_sof   = sof;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got=in_ready stuck 0 expected=accept of %h", p);
    end
    @(negedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  // Pixels with raster indices first..last (index = y*W + x).
  task automatic send_range(input logic [7:0] base, input int first, input int last, input logic sof);
    for (int i = first; i <= last; i++) begin
      push(base + 8'((i / W) * 16 + (i % W)), sof && (i == 0));
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input int start, input logic [7:0] base, input string tag);
    if (cap.size() < start + 6) begin
      checks++;
      failures++;
      $display("FAIL %s_windows: got=%0d expected>=%0d", tag, cap.size(), start + 6);
      return;
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_win%0d", tag, i), cap[start+i].win, exp_win(base, tbl[i].p00));
      check($sformatf("%s_last%0d", tag, i), {71'd0, cap[start+i].last}, {71'd0, tbl[i].last});
`ifdef EMBOSS_WIN_POS_EN
      check($sformatf("%s_cx%0d", tag, i), 72'(cap[start+i].cx), 72'(tbl[i].cx));
      check($sformatf("%s_cy%0d", tag, i), 72'(cap[start+i].cy), 72'(tbl[i].cy));
`endif
    end
  endtask

  initial begin
    tbl[0] = '{8'h00, 1'b0, 1, 1};
    tbl[1] = '{8'h01, 1'b0, 2, 1};
    tbl[2] = '{8'h02, 1'b0, 3, 1};
    tbl[3] = '{8'h10, 1'b0, 1, 2};
    tbl[4] = '{8'h11, 1'b0, 2, 2};
    tbl[5] = '{8'h12, 1'b1, 3, 2};

    // Reset state
    #3;
    check("rst_win_valid", 72'(win_valid), 72'd0);
    check("rst_in_ready", 72'(in_ready), 72'd1);
    check("rst_win_o", win_o, 72'd0);
    check("rst_win_last", 72'(win_last), 72'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Continuous frame, latency and back-to-back window timing
    cap.delete();
    send_range(8'h00, 0, 11, 1'b0);
    check("t1_no_early_valid", 72'(win_valid), 72'd0);
    send_range(8'h00, 12, 12, 1'b0);
    check("t1_valid_after_22", 72'(win_valid), 72'd1);
    send_range(8'h00, 13, 19, 1'b0);
    idle(3);
    check("t1_count", 72'(cap.size()), 72'd6);
    if (cap.size() >= 3) begin
      check("t1_consec_1", 72'(cap[1].cyc - cap[0].cyc), 72'd1);
      check("t1_consec_2", 72'(cap[2].cyc - cap[1].cyc), 72'd1);
    end
    check_frame(0, 8'h00, "t1");

    // Stall on the first window for three cycles
    cap.delete();
    fork
      send_range(8'h00, 0, 19, 1'b0);
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!win_valid && n < 200);
        if (n >= 200) begin
          checks++;
          failures++;
          $display("FAIL t2_wait_valid: got=no window expected=window");
        end
        win_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          check($sformatf("t2_stall_valid%0d", k), 72'(win_valid), 72'd1);
          check($sformatf("t2_stall_ready%0d", k), 72'(in_ready), 72'd0);
          check($sformatf("t2_stall_win%0d", k), win_o, exp_win(8'h00, 8'h00));
          @(negedge clk);
        end
        win_ready = 1'b1;
      end
    join
    idle(3);
    check("t2_count", 72'(cap.size()), 72'd6);
    check_frame(0, 8'h00, "t2");

    // Start-of-frame mid-frame
    cap.delete();
    send_range(8'h00, 0, 6, 1'b0);
    send_range(8'h40, 0, 11, 1'b1);
    check("t3_no_early", 72'(cap.size()), 72'd0);
    send_range(8'h40, 12, 19, 1'b0);
    idle(3);
    check("t3_count", 72'(cap.size()), 72'd6);
    check_frame(0, 8'h40, "t3");

    // Asynchronous reset while a window is pending
    cap.delete();
    send_range(8'h00, 0, 12, 1'b0);
    check("t4_pre_valid", 72'(win_valid), 72'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 72'(win_valid), 72'd0);
    check("t4_rst_ready", 72'(in_ready), 72'd1);
    check("t4_rst_win", win_o, 72'd0);
    check("t4_rst_last", 72'(win_last), 72'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cap.delete();
    send_range(8'h00, 0, 19, 1'b0);
    idle(3);
    check("t4_count", 72'(cap.size()), 72'd6);
    check_frame(0, 8'h00, "t4");

    // Two frames back-to-back
    cap.delete();
    send_range(8'h00, 0, 19, 1'b0);
    send_range(8'h80, 0, 19, 1'b0);
    idle(3);
    check("t5_count", 72'(cap.size()), 72'd12);
    if (cap.size() >= 7) begin
      check("t5_w7_p11", 72'(cap[6].win[4*PW +: PW]), 72'h91);
    end
    check_frame(0, 8'h00, "t5a");
    check_frame(6, 8'h80, "t5b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
